// File: rtl/combo_lock_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock_sequencer_if
//  Description : Switch/button inputs and status/display outputs of the
//                combination lock sequencer, bundled for port connection.
//                master - drives A, B, enter; observes status and displays
//                slave  - the sequencer itself
//  Ports       : A[3:0], B[3:0], enter           (master -> slave)
//                unlocked, error, locked_out,
//                stage[1:0], H1..H6[6:0]          (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface combo_lock_sequencer_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       enter;
    logic       unlocked;
    logic       error;
    logic       locked_out;
    logic [1:0] stage;
    logic [6:0] H1;
    logic [6:0] H2;
    logic [6:0] H3;
    logic [6:0] H4;
    logic [6:0] H5;
    logic [6:0] H6;

    modport master (
        output A, B, enter,
        input  unlocked, error, locked_out, stage, H1, H2, H3, H4, H5, H6
    );

    modport slave (
        input  A, B, enter,
        output unlocked, error, locked_out, stage, H1, H2, H3, H4, H5, H6
    );
endinterface
`default_nettype wire

// File: rtl/combo_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : combo_lock_sequencer
//  Description : Three-stage combination lock controller. Each rising edge of
//                'enter' takes one {A,B} digit pair; after three pairs the
//                collected match bits decide OPEN or FAIL. Repeated failures
//                lead to a timed lockout. Drives six active-low 7-seg digits.
//  Ports       : clock      - system clock, rising edge
//                reset      - synchronous, active-high
//                bus.A/B    - high/low digit of the current entry
//                bus.enter  - entry button (level, synchronous)
//                bus.unlocked/error/locked_out/stage - status
//                bus.H1..H6 - active-low segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module combo_lock_sequencer #(
    parameter logic [7:0] CODE0          = 8'h28,
    parameter logic [7:0] CODE1          = 8'h19,
    parameter logic [7:0] CODE2          = 8'h96,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input  wire logic              clock,
    input  wire logic              reset,
    combo_lock_sequencer_if.slave  bus
);

    localparam int         c_LCW       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_LCW-1:0] c_LOCK_INIT = c_LCW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] c_MAX_FAILS = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_S0      = 3'd0,
        S_S1      = 3'd1,
        S_S2      = 3'd2,
        S_CHECK   = 3'd3,
        S_OPEN    = 3'd4,
        S_FAIL    = 3'd5,
        S_LOCKOUT = 3'd6
    } state_t;

    state_t             r_state;
    logic               r_enter_q;
    logic [2:0]         r_match;
    logic [2:0]         r_fail_cnt;
    logic [c_LCW-1:0]   r_lock_cnt;
    logic               r_error;
    logic [6:0]         r_h1, r_h2, r_h3, r_h4, r_h5, r_h6;

    logic               w_accept;
    logic [7:0]         w_pair;
    logic               w_abort;
    logic [1:0]         w_stage;
    logic [6:0]         w_h6_glyph;

    // Active-high glyph for a hex digit, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_hex(input logic [3:0] d);
        case (d)
            4'h0: f_hex = 7'h3F;
            4'h1: f_hex = 7'h06;
            4'h2: f_hex = 7'h5B;
            4'h3: f_hex = 7'h4F;
            4'h4: f_hex = 7'h66;
            4'h5: f_hex = 7'h6D;
            4'h6: f_hex = 7'h7D;
            4'h7: f_hex = 7'h07;
            4'h8: f_hex = 7'h7F;
            4'h9: f_hex = 7'h6F;
            4'hA: f_hex = 7'h77;
            4'hB: f_hex = 7'h7C;
            4'hC: f_hex = 7'h39;
            4'hD: f_hex = 7'h5E;
            4'hE: f_hex = 7'h79;
            default: f_hex = 7'h71;
        endcase
    endfunction

    // One accept per press, however long the button is held.
    assign w_accept = bus.enter & ~r_enter_q;
    assign w_pair   = {bus.A, bus.B};
    // A 00 pair cancels the sequence in the states that take entries.
    assign w_abort  = w_accept && (w_pair == 8'h00);

    always_comb begin
        w_stage = 2'd0;
        case (r_state)
            S_S1:                      w_stage = 2'd1;
            S_S2:                      w_stage = 2'd2;
            S_CHECK, S_OPEN, S_FAIL:   w_stage = 2'd3;
            default:                   w_stage = 2'd0;
        endcase
    end

    // Status letter: lockout outranks open, open outranks the error flag.
    always_comb begin
        w_h6_glyph = 7'h00;
        if (r_state == S_LOCKOUT)
            w_h6_glyph = 7'h38;
        else if (r_state == S_OPEN)
            w_h6_glyph = 7'h3E;
        else if (r_error)
            w_h6_glyph = 7'h79;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_S0;
            r_enter_q  <= 1'b0;
            r_match    <= 3'b000;
            r_fail_cnt <= 3'd0;
            r_lock_cnt <= '0;
            r_error    <= 1'b0;
            r_h1       <= 7'h7F;
            r_h2       <= 7'h7F;
            r_h3       <= 7'h7F;
            r_h4       <= 7'h7F;
            r_h5       <= 7'h7F;
            r_h6       <= 7'h7F;
        end else begin
            r_enter_q <= bus.enter;

            r_h1 <= ~f_hex(bus.A);
            r_h2 <= ~f_hex(bus.B);
            r_h3 <= ~f_hex({2'b00, w_stage});
            r_h4 <= ~f_hex({1'b0, r_fail_cnt});
            r_h5 <= 7'h7F;
            r_h6 <= ~w_h6_glyph;

            case (r_state)
                S_S0: begin
                    if (w_abort) begin
                        r_match <= 3'b000;
                        r_error <= 1'b0;
                    end else if (w_accept) begin
                        r_match[0] <= (w_pair == CODE0);
                        r_error    <= 1'b0;
                        r_state    <= S_S1;
                    end
                end
                S_S1: begin
                    if (w_abort) begin
                        r_match <= 3'b000;
                        r_error <= 1'b0;
                        r_state <= S_S0;
                    end else if (w_accept) begin
                        r_match[1] <= (w_pair == CODE1);
                        r_state    <= S_S2;
                    end
                end
                S_S2: begin
                    if (w_abort) begin
                        r_match <= 3'b000;
                        r_error <= 1'b0;
                        r_state <= S_S0;
                    end else if (w_accept) begin
                        r_match[2] <= (w_pair == CODE2);
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_match == 3'b111) begin
                        r_fail_cnt <= 3'd0;
                        r_state    <= S_OPEN;
                    end else begin
                        r_state    <= S_FAIL;
                    end
                end
                S_OPEN: begin
                    // Any press relocks; a 00 press is just a relock too.
                    if (w_accept) begin
                        r_match <= 3'b000;
                        r_state <= S_S0;
                        if (w_abort)
                            r_error <= 1'b0;
                    end
                end
                S_FAIL: begin
                    r_error <= 1'b1;
                    if (r_fail_cnt + 3'd1 == c_MAX_FAILS) begin
                        r_lock_cnt <= c_LOCK_INIT;
                        r_state    <= S_LOCKOUT;
                    end else begin
                        r_fail_cnt <= r_fail_cnt + 3'd1;
                        r_state    <= S_S0;
                    end
                end
                S_LOCKOUT: begin
                    // Counts LOCKOUT_CYCLES cycles in total, from N-1 down to 0.
                    if (r_lock_cnt == '0) begin
                        r_fail_cnt <= 3'd0;
                        r_error    <= 1'b0;
                        r_state    <= S_S0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                    end
                end
                default: r_state <= S_S0;
            endcase
        end
    end

    assign bus.unlocked   = (r_state == S_OPEN);
    assign bus.locked_out = (r_state == S_LOCKOUT);
    assign bus.error      = r_error;
    assign bus.stage      = w_stage;
    assign bus.H1         = r_h1;
    assign bus.H2         = r_h2;
    assign bus.H3         = r_h3;
    assign bus.H4         = r_h4;
    assign bus.H5         = r_h5;
    assign bus.H6         = r_h6;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_combo_lock_sequencer
//  Description : Self-checking bench for combo_lock_sequencer. Expected values
//                are queued when stimulus is applied and compared against the
//                DUT once the corresponding outputs are due.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_combo_lock_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    combo_lock_sequencer_if bus ();

    combo_lock_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Observable selectors
    localparam int O_UNL = 0, O_ERR = 1, O_LCK = 2, O_STG = 3, O_H1 = 4,
                   O_H2 = 5, O_H3 = 6, O_H4 = 7, O_H5 = 8, O_H6 = 9;

    logic [6:0] seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        string      name;
        int         sel;
        logic [6:0] exp;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [7:0] p0, p1, p2;
        logic       unl;
        logic       err;
        logic [3:0] fcnt;
        logic [1:0] stg;
        logic [6:0] h6;
    } vec_t;
    vec_t vecs[6];

    int total = 0;
    int bad   = 0;

    function automatic logic [6:0] hx(input logic [3:0] d);
        return ~seg[d];
    endfunction

    function automatic logic [6:0] observe(input int sel);
        case (sel)
            O_UNL:   return {6'b0, bus.unlocked};
            O_ERR:   return {6'b0, bus.error};
            O_LCK:   return {6'b0, bus.locked_out};
            O_STG:   return {5'b0, bus.stage};
            O_H1:    return bus.H1;
            O_H2:    return bus.H2;
            O_H3:    return bus.H3;
            O_H4:    return bus.H4;
            O_H5:    return bus.H5;
            default: return bus.H6;
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic exp_v(input string name, input int sel, input logic [6:0] e);
        sb_t s;
        s.name = name;
        s.sel  = sel;
        s.exp  = e;
        sbq.push_back(s);
    endtask

    task automatic drain();
        sb_t s;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            cmp(s.name, {25'b0, observe(s.sel)}, {25'b0, s.exp});
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [7:0] p);
        bus.A     = p[7:4];
        bus.B     = p[3:0];
        bus.enter = 1'b1;
        step();
        bus.enter = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.enter = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        bus.A     = 4'h0;
        bus.B     = 4'h0;
        bus.enter = 1'b0;

        vecs[0] = '{8'h28, 8'h19, 8'h96, 1'b1, 1'b0, 4'd0, 2'd3, 7'h3E};
        vecs[1] = '{8'h28, 8'h19, 8'h95, 1'b0, 1'b1, 4'd1, 2'd0, 7'h79};
        vecs[2] = '{8'h27, 8'h19, 8'h96, 1'b0, 1'b1, 4'd1, 2'd0, 7'h79};
        vecs[3] = '{8'h28, 8'h18, 8'h96, 1'b0, 1'b1, 4'd1, 2'd0, 7'h79};
        vecs[4] = '{8'h96, 8'h19, 8'h28, 1'b0, 1'b1, 4'd1, 2'd0, 7'h79};
        vecs[5] = '{8'hAB, 8'hCD, 8'hEF, 1'b0, 1'b1, 4'd1, 2'd0, 7'h79};

        // Reset state, observed while reset is still asserted
        reset = 1'b1;
        step();
        step();
        exp_v("rst_unlocked", O_UNL, 7'd0);
        exp_v("rst_error",    O_ERR, 7'd0);
        exp_v("rst_locked",   O_LCK, 7'd0);
        exp_v("rst_stage",    O_STG, 7'd0);
        exp_v("rst_h1",       O_H1,  7'h7F);
        exp_v("rst_h4",       O_H4,  7'h7F);
        exp_v("rst_h6",       O_H6,  7'h7F);
        drain();
        reset = 1'b0;

        // Table: one full sequence from reset per record
        for (int i = 0; i < 6; i++) begin
            do_reset();
            press(vecs[i].p0);
            press(vecs[i].p1);
            press(vecs[i].p2);
            exp_v($sformatf("v%0d_lat_unlocked", i), O_UNL, {6'b0, vecs[i].unl});
            drain();
            step();
            step();
            exp_v($sformatf("v%0d_unlocked", i), O_UNL, {6'b0, vecs[i].unl});
            exp_v($sformatf("v%0d_error", i),    O_ERR, {6'b0, vecs[i].err});
            exp_v($sformatf("v%0d_locked", i),   O_LCK, 7'd0);
            exp_v($sformatf("v%0d_stage", i),    O_STG, {5'b0, vecs[i].stg});
            exp_v($sformatf("v%0d_h1", i),       O_H1,  hx(vecs[i].p2[7:4]));
            exp_v($sformatf("v%0d_h2", i),       O_H2,  hx(vecs[i].p2[3:0]));
            exp_v($sformatf("v%0d_h3", i),       O_H3,  hx({2'b00, vecs[i].stg}));
            exp_v($sformatf("v%0d_h4", i),       O_H4,  hx(vecs[i].fcnt));
            exp_v($sformatf("v%0d_h5", i),       O_H5,  7'h7F);
            exp_v($sformatf("v%0d_h6", i),       O_H6,  ~vecs[i].h6);
            drain();
        end

        // Abort after one entry keeps fail count, then a clean sequence opens
        do_reset();
        press(8'h28); press(8'h19); press(8'h95);
        step(); step();
        exp_v("ab_pre_error", O_ERR, 7'd1);
        drain();
        press(8'h28);
        exp_v("ab_stage1", O_STG, 7'd1);
        exp_v("ab_err_clr", O_ERR, 7'd0);
        drain();
        press(8'h00);
        exp_v("ab_stage0", O_STG, 7'd0);
        exp_v("ab_error",  O_ERR, 7'd0);
        step();
        drain();
        exp_v("ab_failcnt", O_H4, hx(4'd1));
        exp_v("ab_h3",      O_H3, hx(4'd0));
        drain();
        press(8'h28); press(8'h19); press(8'h96);
        exp_v("ab_reopen", O_UNL, 7'd1);
        drain();
        step();
        exp_v("open_failcnt0", O_H4, hx(4'd0));
        drain();
        press(8'h55);
        exp_v("relock_unl",   O_UNL, 7'd0);
        exp_v("relock_stage", O_STG, 7'd0);
        drain();

        // Three failures -> lockout for 16 cycles, presses ignored
        do_reset();
        for (int k = 0; k < 2; k++) begin
            press(8'h28); press(8'h19); press(8'h95);
            step(); step();
        end
        press(8'h28); press(8'h19); press(8'h95);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.locked_out) begin
                cnt++;
                if (cnt == 1) begin
                    exp_v("lo_stage", O_STG, 7'd0);
                    exp_v("lo_unl",   O_UNL, 7'd0);
                    drain();
                end
                bus.A     = 4'h2;
                bus.B     = 4'h8;
                bus.enter = ~bus.enter;
            end else if (cnt > 0) begin
                break;
            end
        end
        bus.enter = 1'b0;
        cmp("lockout_len", cnt, 16);
        exp_v("lo_end_locked", O_LCK, 7'd0);
        exp_v("lo_end_stage",  O_STG, 7'd0);
        drain();
        step();
        exp_v("lo_end_h6",    O_H6,  7'h7F);
        exp_v("lo_end_h4",    O_H4,  hx(4'd0));
        exp_v("lo_end_error", O_ERR, 7'd0);
        exp_v("lo_end_stage2", O_STG, 7'd0);
        drain();

        // Held button gives exactly one accept
        do_reset();
        bus.A     = 4'h2;
        bus.B     = 4'h8;
        bus.enter = 1'b1;
        repeat (10) step();
        exp_v("hold_stage", O_STG, 7'd1);
        drain();
        bus.enter = 1'b0;
        step();
        exp_v("hold_stage_after", O_STG, 7'd1);
        drain();

        // Reset in S2 discards the partial code
        do_reset();
        press(8'h28); press(8'h19);
        exp_v("s2_stage", O_STG, 7'd2);
        drain();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_v("rst_s2_stage", O_STG, 7'd0);
        drain();
        press(8'h96);
        step(); step();
        exp_v("rst_s2_unl",   O_UNL, 7'd0);
        exp_v("rst_s2_stage1", O_STG, 7'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
